// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: block size, engine states,
// the inverse S-box table and the byte-position helper.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [7:0] INV_S_BOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte 0 is the MSB of the 128-bit state.
    function automatic int byte_lsb(input int idx);
        return 8 * (AES_BLOCK_BYTES - 1 - idx);
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// One combinational AES inverse S-box lookup.
// Ports: din (byte in), dout (InvSubByte(din)).
module inv_s_box
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = INV_S_BOX[din];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine, LANES bytes per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data
// accept a 128-bit state; out_valid/out_ready/out_data return it.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int N  = AES_BLOCK_BYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   st_q, st_d;
    logic [7:0]     lane_in  [LANES];
    logic [7:0]     lane_out [LANES];

    // Lane i works on byte cnt*LANES+i of the state register.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] =
            st_q[byte_lsb(int'(cnt_q) * LANES + i) +: 8];

        inv_s_box u_sbox (
            .din  (lane_in[i]),
            .dout (lane_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    st_d[byte_lsb(int'(cnt_q) * LANES + i) +: 8] =
                        lane_out[i];
                end
                // Counter wraps to 0 on the last beat so the lane
                // index never leaves the block while idle.
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = st_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: LANES=4 main instance,
// LANES=1 and LANES=16 instances for the round-trip sweep.
module tb_inv_sub_bytes_seq;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [127:0] KV_IN  =
        128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] KV_OUT =
        128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
    logic         ir1, ov1, ir4, ov4, ir16, ov16;
    logic [127:0] od1, od4, od16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
    );

    inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
    );

    inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir16), .in_data(in_data),
        .out_valid(ov16), .out_ready(out_ready), .out_data(od16)
    );

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fwd(input logic [127:0] x);
        logic [127:0] y;
        for (int k = 0; k < 16; k++) y[8*k +: 8] = SBOX[x[8*k +: 8]];
        return y;
    endfunction

    // Sends one block to all instances, waits for the LANES=4 result.
    // lat counts cycles from the accept cycle (0) to out_valid.
    task automatic run4(input logic [127:0] data,
                        output logic [127:0] res,
                        output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!ov4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = od4;
    endtask

    task automatic take;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res, hold, x, r1, r4, r16;
        int lat, cyc, l1, l4, l16, seen;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", ir4, 1'b1);
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_out_data", od4, '0);

        run4(KV_IN, res, lat);
        chk("kv_data", res, KV_OUT);
        chk("kv_latency", 128'(lat), 128'd5);
        take();
        chk("kv_post_out_valid", ov4, 1'b0);
        chk("kv_post_in_ready", ir4, 1'b1);

        run4({16{8'h16}}, res, lat);
        chk("uni16_data", res, {16{8'hff}});
        take();
        run4({16{8'h00}}, res, lat);
        chk("uni00_data", res, {16{8'h52}});
        chk("uni00_latency", 128'(lat), 128'd5);
        take();

        run4(KV_IN, res, lat);
        hold = res;
        in_valid = 1'b1;
        in_data  = {16{8'h63}};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_data", od4, hold);
            chk("bp_out_valid", ov4, 1'b1);
            chk("bp_in_ready", ir4, 1'b0);
        end
        take();
        chk("bp_u1_in_ready", ir4, 1'b1);
        chk("bp_u1_out_valid", ov4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!ov4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_latency", 128'(lat), 128'd5);
        chk("bp_second_data", od4, {16{8'h00}});
        take();

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = KV_IN;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", ov4, 1'b0);
        chk("mid_rst_out_data", od4, '0);
        chk("mid_rst_in_ready", ir4, 1'b1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov4) seen++;
        end
        chk("mid_rst_no_valid", 128'(seen), '0);
        chk("mid_rst_data_zero", od4, '0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 1000; b++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fwd(x);
            @(negedge clk);
            in_valid = 1'b0;
            cyc = 1;
            l1 = 0;
            l4 = 0;
            l16 = 0;
            r1 = '0;
            r4 = '0;
            r16 = '0;
            while (cyc < 40) begin
                if (ov1 && l1 == 0) begin
                    l1 = cyc;
                    r1 = od1;
                end
                if (ov4 && l4 == 0) begin
                    l4 = cyc;
                    r4 = od4;
                end
                if (ov16 && l16 == 0) begin
                    l16 = cyc;
                    r16 = od16;
                end
                if (l1 != 0 && l4 != 0 && l16 != 0) break;
                @(negedge clk);
                cyc++;
            end
            chk("rt_l1_data", r1, x);
            chk("rt_l4_data", r4, x);
            chk("rt_l16_data", r16, x);
            chk("rt_l1_latency", 128'(l1), 128'd17);
            chk("rt_l4_latency", 128'(l4), 128'd5);
            chk("rt_l16_latency", 128'(l16), 128'd2);
            take();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
